// File: rtl/i2c_cfg_slave_pkg.sv
// Shared types and constants for the I2C configuration target.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control; the bus master owns SCL).
package i2c_cfg_slave_pkg;

    // Protocol phases of the target, one per byte/acknowledge slot
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_e;

    // Register map
    localparam logic [2:0] REG_WAVE     = 3'd0;
    localparam logic [2:0] REG_FREQ0    = 3'd1;
    localparam logic [2:0] REG_FREQ1    = 3'd2;
    localparam logic [2:0] REG_FREQ2    = 3'd3;
    localparam logic [2:0] REG_FREQ3    = 3'd4;
    localparam logic [2:0] REG_PHASE_LO = 3'd5;
    localparam logic [2:0] REG_PHASE_HI = 3'd6;
    localparam logic [2:0] REG_ID       = 3'd7;

    // Defaults for the top-level parameters
    localparam logic [6:0]  DEV_ADDR_DEF  = 7'h50;
    localparam logic [7:0]  ID_VAL_DEF    = 8'hA5;
    localparam logic [31:0] FREQ_RST_DEF  = 32'd3615292;
    localparam logic [11:0] PHASE_RST_DEF = 12'd0;

    // Byte view of the register map; unused high nibbles read as zero
    function automatic logic [7:0] cfg_reg_read(
        input logic [2:0]  addr,
        input logic [3:0]  wave,
        input logic [31:0] freq,
        input logic [11:0] phase,
        input logic [7:0]  id
    );
        logic [7:0] rd;
        case (addr)
            REG_WAVE:     rd = {4'h0, wave};
            REG_FREQ0:    rd = freq[7:0];
            REG_FREQ1:    rd = freq[15:8];
            REG_FREQ2:    rd = freq[23:16];
            REG_FREQ3:    rd = freq[31:24];
            REG_PHASE_LO: rd = phase[7:0];
            REG_PHASE_HI: rd = {4'h0, phase[11:8]};
            default:      rd = id;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into sys_clk and flags START, STOP and SCL edges.
// Latency: event pulses assert 2 sys_clk after the pin changes (acted on at the 3rd edge).
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    // [0],[1] form the synchroniser, [2] is the history flop for edge detection
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Sample the pins; reset to the idle (released, high) bus level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    // Bus conditions from the synchronised level and its one-cycle history
    always_comb begin
        sda_o      = sda_q[1];
        scl_rise_o = scl_q[1] & ~scl_q[2];
        scl_fall_o = ~scl_q[1] & scl_q[2];
        start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
        stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end

endmodule

// File: rtl/i2c_cfg_slave.sv
// I2C target exposing an 8-byte DDS configuration map; commits shadows on STOP.
// Latency: outputs update 1 sys_clk after STOP is detected, cfg_update pulses the cycle after.
// Backpressure: none; no clock stretching, SCL must stay at or below 400 kHz.
module i2c_cfg_slave
    import i2c_cfg_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEF,
    parameter logic [31:0] FREQ_RST  = FREQ_RST_DEF,
    parameter logic [11:0] PHASE_RST = PHASE_RST_DEF,
    parameter logic [7:0]  ID_VAL    = ID_VAL_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i2c_scl,
    input  logic        i2c_sda_i,
    output logic        i2c_sda_oe,
    output logic [3:0]  wave_select,
    output logic [31:0] freq_ctrl,
    output logic [11:0] phase_ctrl,
    output logic        cfg_update
);

    logic sda_s, start_p, stop_p, rise_p, fall_p;

    i2c_bus_sync u_sync (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .scl_i      (i2c_scl),
        .sda_i      (i2c_sda_i),
        .sda_o      (sda_s),
        .start_o    (start_p),
        .stop_o     (stop_p),
        .scl_rise_o (rise_p),
        .scl_fall_o (fall_p)
    );

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        ack_q, ack_d;
    logic        dirty_q, dirty_d;
    logic [3:0]  sh_wave_q, sh_wave_d;
    logic [31:0] sh_freq_q, sh_freq_d;
    logic [11:0] sh_phase_q, sh_phase_d;
    logic [3:0]  wave_q, wave_d;
    logic [31:0] freq_q, freq_d;
    logic [11:0] phase_q, phase_d;
    logic        commit_q, commit_d;
    logic        upd_q, upd_d;
    logic [7:0]  rd_cur, rd_nxt;

    // Read data for the current pointer and for the pointer after an ACKed read
    assign rd_cur = cfg_reg_read(ptr_q, sh_wave_q, sh_freq_q, sh_phase_q, ID_VAL);
    assign rd_nxt = cfg_reg_read(ptr_q + 3'd1, sh_wave_q, sh_freq_q, sh_phase_q, ID_VAL);

    // State, shadow and committed registers; reset discards uncommitted writes
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 3'd0;
            oe_q       <= 1'b0;
            ack_q      <= 1'b1;
            dirty_q    <= 1'b0;
            sh_wave_q  <= 4'd0;
            sh_freq_q  <= FREQ_RST;
            sh_phase_q <= PHASE_RST;
            wave_q     <= 4'd0;
            freq_q     <= FREQ_RST;
            phase_q    <= PHASE_RST;
            commit_q   <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            dirty_q    <= dirty_d;
            sh_wave_q  <= sh_wave_d;
            sh_freq_q  <= sh_freq_d;
            sh_phase_q <= sh_phase_d;
            wave_q     <= wave_d;
            freq_q     <= freq_d;
            phase_q    <= phase_d;
            commit_q   <= commit_d;
            upd_q      <= upd_d;
        end
    end

    // Protocol sequencing: bits are taken on SCL rise, SDA drive changes on SCL fall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        ack_d      = ack_q;
        dirty_d    = dirty_q;
        sh_wave_d  = sh_wave_q;
        sh_freq_d  = sh_freq_q;
        sh_phase_d = sh_phase_q;
        wave_d     = wave_q;
        freq_d     = freq_q;
        phase_d    = phase_q;
        commit_d   = 1'b0;
        upd_d      = commit_q;

        if (stop_p) begin
            // STOP ends any transfer; publish shadows only if something was written
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            if (dirty_q) begin
                wave_d   = sh_wave_q;
                freq_d   = sh_freq_q;
                phase_d  = sh_phase_q;
                commit_d = 1'b1;
                dirty_d  = 1'b0;
            end
        end else if (start_p) begin
            // START or repeated START: restart address phase, pointer and dirty kept
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (rise_p && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_p && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall_p) begin
                        cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d = ST_RDATA;
                            shift_d = rd_cur;
                            oe_d    = ~rd_cur[7];
                        end else begin
                            state_d = ST_REG;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_REG: begin
                    if (rise_p && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_p && cnt_q == 4'd8) begin
                        ptr_d   = shift_q[2:0];
                        oe_d    = 1'b1;
                        state_d = ST_REG_ACK;
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (fall_p) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (rise_p && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_p && cnt_q == 4'd8) begin
                        case (ptr_q)
                            REG_WAVE:     sh_wave_d         = shift_q[3:0];
                            REG_FREQ0:    sh_freq_d[7:0]    = shift_q;
                            REG_FREQ1:    sh_freq_d[15:8]   = shift_q;
                            REG_FREQ2:    sh_freq_d[23:16]  = shift_q;
                            REG_FREQ3:    sh_freq_d[31:24]  = shift_q;
                            REG_PHASE_LO: sh_phase_d[7:0]   = shift_q;
                            REG_PHASE_HI: sh_phase_d[11:8]  = shift_q[3:0];
                            default: begin
                            end
                        endcase
                        // The ID byte is read-only, so writing it does not dirty the map
                        if (ptr_q != REG_ID) begin
                            dirty_d = 1'b1;
                        end
                        ptr_d   = ptr_q + 3'd1;
                        oe_d    = 1'b1;
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (fall_p) begin
                        if (cnt_q == 4'd7) begin
                            oe_d    = 1'b0;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (rise_p) begin
                        ack_d = sda_s;
                    end else if (fall_p) begin
                        if (!ack_q) begin
                            ptr_d   = ptr_q + 3'd1;
                            shift_d = rd_nxt;
                            oe_d    = ~rd_nxt[7];
                            cnt_d   = 4'd0;
                            state_d = ST_RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign i2c_sda_oe  = oe_q;
    assign wave_select = wave_q;
    assign freq_ctrl   = freq_q;
    assign phase_ctrl  = phase_q;
    assign cfg_update  = upd_q;

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Bench: bit-banged I2C master against a register-map model of the target.
// Latency: compare process samples every falling sys_clk edge.
// Backpressure: n/a; the master paces SCL at 400 kHz.
module tb_i2c_cfg_slave;

    localparam int          Q        = 625;          // quarter SCL period (sys_clk period is 20)
    localparam logic [31:0] FREQ_RST = 32'd3615292;

    logic        sys_clk;
    logic        sys_rst;
    logic        i2c_scl;
    logic        sda_m;
    logic        sda_line;
    logic        i2c_sda_oe;
    logic [3:0]  wave_select;
    logic [31:0] freq_ctrl;
    logic [11:0] phase_ctrl;
    logic        cfg_update;

    // Open-drain bus: either side can pull low
    assign sda_line = sda_m & ~i2c_sda_oe;

    i2c_cfg_slave #(
        .DEV_ADDR  (7'h50),
        .FREQ_RST  (FREQ_RST),
        .PHASE_RST (12'd0),
        .ID_VAL    (8'hA5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .i2c_scl     (i2c_scl),
        .i2c_sda_i   (sda_line),
        .i2c_sda_oe  (i2c_sda_oe),
        .wave_select (wave_select),
        .freq_ctrl   (freq_ctrl),
        .phase_ctrl  (phase_ctrl),
        .cfg_update  (cfg_update)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // ---------------- model: register bytes as seen on the bus ----------------
    logic [7:0]  m_reg [0:7];
    logic [2:0]  m_ptr;
    bit          m_dirty;
    logic [3:0]  c_wave;
    logic [31:0] c_freq;
    logic [11:0] c_phase;
    int          exp_pulses = 0;
    int          act_pulses = 0;
    bit          chk_en = 0;
    bit          oe_mon = 0;
    int          oe_hits = 0;
    int          cmp_prints = 0;
    logic        upd_prev = 1'b0;
    logic        oe_prev = 1'b0;

    function automatic logic [3:0]  m_wave();  return m_reg[0][3:0]; endfunction
    function automatic logic [31:0] m_freq();  return {m_reg[4], m_reg[3], m_reg[2], m_reg[1]}; endfunction
    function automatic logic [11:0] m_phase(); return {m_reg[6][3:0], m_reg[5]}; endfunction

    task automatic m_commit();
        c_wave  = m_wave();
        c_freq  = m_freq();
        c_phase = m_phase();
    endtask

    task automatic m_reset();
        m_reg[0] = 8'h00;
        m_reg[1] = FREQ_RST[7:0];
        m_reg[2] = FREQ_RST[15:8];
        m_reg[3] = FREQ_RST[23:16];
        m_reg[4] = FREQ_RST[31:24];
        m_reg[5] = 8'h00;
        m_reg[6] = 8'h00;
        m_reg[7] = 8'hA5;
        m_ptr    = 3'd0;
        m_dirty  = 0;
        m_commit();
    endtask

    task automatic m_write(input logic [7:0] b);
        if (m_ptr == 3'd0 || m_ptr == 3'd6) begin
            m_reg[m_ptr] = {4'h0, b[3:0]};
            m_dirty = 1;
        end else if (m_ptr != 3'd7) begin
            m_reg[m_ptr] = b;
            m_dirty = 1;
        end
        m_ptr = m_ptr + 3'd1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge sys_clk) begin
        if (chk_en) begin
            checks++;
            if (wave_select !== c_wave || freq_ctrl !== c_freq || phase_ctrl !== c_phase) begin
                errors++;
                if (cmp_prints < 10)
                    $display("FAIL outputs: got wave=%h freq=%h phase=%h, expected wave=%h freq=%h phase=%h",
                             wave_select, freq_ctrl, phase_ctrl, c_wave, c_freq, c_phase);
                cmp_prints++;
            end
        end
        if (cfg_update === 1'b1) begin
            act_pulses++;
            checks++;
            if (upd_prev === 1'b1 || wave_select !== m_wave() || freq_ctrl !== m_freq() ||
                phase_ctrl !== m_phase()) begin
                errors++;
                $display("FAIL update_pulse: got wave=%h freq=%h phase=%h prev=%b, expected wave=%h freq=%h phase=%h prev=0",
                         wave_select, freq_ctrl, phase_ctrl, upd_prev, m_wave(), m_freq(), m_phase());
            end
        end
        if (!sys_rst && i2c_sda_oe !== oe_prev) begin
            checks++;
            if (i2c_scl !== 1'b0) begin
                errors++;
                $display("FAIL oe_edge: got oe change with scl=%b, expected scl=0", i2c_scl);
            end
        end
        if (oe_mon && i2c_sda_oe === 1'b1) oe_hits++;
        upd_prev = cfg_update;
        oe_prev  = i2c_sda_oe;
    end

    // ---------------- bit-level master ----------------
    task automatic write_bit(input logic b);
        sda_m = b;   #Q;
        i2c_scl = 1; #(2*Q);
        i2c_scl = 0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1;   #Q;
        i2c_scl = 1; #Q;
        b = sda_line; #Q;
        i2c_scl = 0; #Q;
    endtask

    task automatic i2c_start();
        sda_m = 0;   #Q;
        i2c_scl = 0; #Q;
    endtask

    task automatic i2c_rstart();
        sda_m = 1;   #Q;
        i2c_scl = 1; #Q;
        sda_m = 0;   #Q;
        i2c_scl = 0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 0;   #Q;
        i2c_scl = 1; #Q;
        chk_en = 0;
        sda_m = 1;
        repeat (10) @(posedge sys_clk);
        if (m_dirty) begin
            m_commit();
            exp_pulses++;
            m_dirty = 0;
        end
        chk_en = 1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        chk(nm, {31'd0, ~a}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(nack);
    endtask

    task automatic rd_chk(input logic nack, input string nm, output logic [7:0] got);
        recv_byte(nack, got);
        chk(nm, {24'd0, got}, {24'd0, m_reg[m_ptr]});
        if (!nack) m_ptr = m_ptr + 3'd1;
    endtask

    // Watchdog: the bench never waits on a DUT event, but guard anyway
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic [7:0] got;
    logic [7:0] rd_lit [0:8];

    initial begin
        rd_lit[0] = 8'h03; rd_lit[1] = 8'h11; rd_lit[2] = 8'h22; rd_lit[3] = 8'h33;
        rd_lit[4] = 8'h44; rd_lit[5] = 8'h00; rd_lit[6] = 8'h00; rd_lit[7] = 8'hA5;
        rd_lit[8] = 8'h03;

        sys_rst = 1; i2c_scl = 1; sda_m = 1;
        m_reset();
        repeat (5) @(posedge sys_clk);
        #1;
        chk("rst_oe",     {31'd0, i2c_sda_oe}, 32'd0);
        chk("rst_wave",   {28'd0, wave_select}, 32'd0);
        chk("rst_freq",   freq_ctrl, 32'd3615292);
        chk("rst_phase",  {20'd0, phase_ctrl}, 32'd0);
        chk("rst_update", {31'd0, cfg_update}, 32'd0);
        sys_rst = 0;
        chk_en = 1;
        #(4*Q);

        // Write four frequency bytes starting at 0x01
        i2c_start();
        send_byte(8'hA0, 1, "t1_addr_ack");
        send_byte(8'h01, 1, "t1_reg_ack");
        m_ptr = 3'd1;
        send_byte(8'h11, 1, "t1_d0_ack"); m_write(8'h11);
        send_byte(8'h22, 1, "t1_d1_ack"); m_write(8'h22);
        send_byte(8'h33, 1, "t1_d2_ack"); m_write(8'h33);
        send_byte(8'h44, 1, "t1_d3_ack"); m_write(8'h44);
        i2c_stop();
        chk("t1_freq",   freq_ctrl, 32'h44332211);
        chk("t1_wave",   {28'd0, wave_select}, 32'd0);
        chk("t1_phase",  {20'd0, phase_ctrl}, 32'd0);
        chk("t1_pulses", act_pulses, 1);

        // Write wave, repeated STARTs, read all 9 bytes with wrap
        i2c_start();
        send_byte(8'hA0, 1, "t2_addr_ack");
        send_byte(8'h00, 1, "t2_reg_ack");
        m_ptr = 3'd0;
        send_byte(8'h03, 1, "t2_d_ack"); m_write(8'h03);
        i2c_rstart();
        send_byte(8'hA0, 1, "t2_addr2_ack");
        send_byte(8'h00, 1, "t2_reg2_ack");
        m_ptr = 3'd0;
        i2c_rstart();
        send_byte(8'hA1, 1, "t2_addr_rd_ack");
        for (int i = 0; i < 9; i++) begin
            rd_chk(i == 8, "t2_rd_model", got);
            chk("t2_rd_lit", {24'd0, got}, {24'd0, rd_lit[i]});
        end
        chk("t2_no_early_pulse", act_pulses, 1);
        chk("t2_wave_before_stop", {28'd0, wave_select}, 32'd0);
        i2c_stop();
        chk("t2_wave",   {28'd0, wave_select}, 32'd3);
        chk("t2_pulses", act_pulses, exp_pulses);

        // Foreign address: no ACK, nothing driven, pointer untouched
        oe_hits = 0;
        oe_mon  = 1;
        i2c_start();
        send_byte(8'hA2, 0, "t3_addr_nack");
        send_byte(8'h00, 0, "t3_data_nack");
        i2c_stop();
        oe_mon = 0;
        chk("t3_oe_hits", oe_hits, 0);
        chk("t3_pulses",  act_pulses, 2);
        i2c_start();
        send_byte(8'hA1, 1, "t3_rd_addr_ack");
        rd_chk(1, "t3_ptr_read", got);
        chk("t3_ptr_lit", {24'd0, got}, 32'h03);
        i2c_stop();

        // ID register is read-only
        i2c_start();
        send_byte(8'hA0, 1, "t4_addr_ack");
        send_byte(8'h07, 1, "t4_reg_ack");
        m_ptr = 3'd7;
        send_byte(8'h00, 1, "t4_d_ack"); m_write(8'h00);
        i2c_stop();
        chk("t4_pulses", act_pulses, exp_pulses);
        i2c_start();
        send_byte(8'hA0, 1, "t4_addr2_ack");
        send_byte(8'h07, 1, "t4_reg2_ack");
        m_ptr = 3'd7;
        i2c_rstart();
        send_byte(8'hA1, 1, "t4_rd_addr_ack");
        rd_chk(1, "t4_id_model", got);
        chk("t4_id_lit", {24'd0, got}, 32'hA5);
        i2c_stop();

        // Phase write, high nibble masked to 4 bits
        i2c_start();
        send_byte(8'hA0, 1, "t5_addr_ack");
        send_byte(8'h05, 1, "t5_reg_ack");
        m_ptr = 3'd5;
        send_byte(8'hFF, 1, "t5_d0_ack"); m_write(8'hFF);
        send_byte(8'h1F, 1, "t5_d1_ack"); m_write(8'h1F);
        i2c_stop();
        chk("t5_phase",  {20'd0, phase_ctrl}, 32'hFFF);
        chk("t5_wave",   {28'd0, wave_select}, 32'd3);
        chk("t5_pulses", act_pulses, 3);

        // Reset during the 4th bit of the second data byte
        i2c_start();
        send_byte(8'hA0, 1, "t6_addr_ack");
        send_byte(8'h01, 1, "t6_reg_ack");
        m_ptr = 3'd1;
        send_byte(8'h99, 1, "t6_d0_ack"); m_write(8'h99);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
        sda_m = 1;   #Q;
        i2c_scl = 1; #Q;
        chk_en = 0;
        sys_rst = 1;
        @(posedge sys_clk); #1;
        chk("t6_oe_in_rst",   {31'd0, i2c_sda_oe}, 32'd0);
        chk("t6_freq_in_rst", freq_ctrl, 32'd3615292);
        m_reset();
        repeat (3) @(posedge sys_clk);
        sys_rst = 0;
        #Q;
        i2c_scl = 0;
        chk_en = 1;
        #Q;
        i2c_stop();
        chk("t6_freq_after", freq_ctrl, 32'd3615292);
        chk("t6_pulses",     act_pulses, 3);
        i2c_start();
        send_byte(8'hA0, 1, "t6_new_addr_ack");
        send_byte(8'h02, 1, "t6_new_reg_ack");
        m_ptr = 3'd2;
        send_byte(8'h77, 1, "t6_new_d_ack"); m_write(8'h77);
        i2c_stop();
        chk("t6_new_freq",   freq_ctrl, 32'h0037773C);
        chk("t6_new_pulses", act_pulses, exp_pulses);
        chk("t6_pulses_lit", act_pulses, 4);

        #(4*Q);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
